// File: rtl/vc_input_unit.sv
// Multi-VC router input unit: per-VC FIFO with IDLE/VA/SA packet FSM, VA/SA
// request generation, on/off flow control and sticky protocol-error flags.
package noc_params;
  localparam int VC_SIZE = 1;

  typedef enum logic [2:0] {LOCAL, NORTH, SOUTH, WEST, EAST} port_t;
  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

  typedef struct packed {
    flit_label_t          flit_label;
    logic [VC_SIZE-1:0]   vc_id;
    logic [15:0]          data;
  } flit_t;
endpackage

// state | meaning
// IDLE  | no packet owns the VC; waits for HEAD/HEADTAIL
// VA    | head buffered, requesting a downstream VC
// SA    | downstream VC held, requesting the switch while non-empty
module vc_input_unit
  import noc_params::*;
#(
  parameter int VC_NUM      = 2**VC_SIZE,
  parameter int BUFFER_SIZE = 8,
  parameter int OFF_MARGIN  = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  flit_t                            data_i,
  input  logic                             valid_i,
  input  port_t                            out_port_i,
  input  logic [VC_NUM-1:0]                vc_valid_i,
  input  logic [VC_NUM-1:0][VC_SIZE-1:0]   vc_new_i,
  input  logic [VC_NUM-1:0]                read_i,
  output flit_t                            data_o,
  output logic [VC_NUM-1:0]                is_full_o,
  output logic [VC_NUM-1:0]                is_empty_o,
  output logic [VC_NUM-1:0]                on_off_o,
  output port_t [VC_NUM-1:0]               out_port_o,
  output logic [VC_NUM-1:0]                vc_request_o,
  output logic [VC_NUM-1:0]                switch_request_o,
  output logic [VC_NUM-1:0]                vc_allocatable_o,
  output logic [VC_NUM-1:0][VC_SIZE-1:0]   downstream_vc_o,
  output logic [VC_NUM-1:0]                error_o
);

  localparam int PTR_W = $clog2(BUFFER_SIZE);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUFFER_SIZE);
  localparam logic [CNT_W-1:0] ON_LIMIT = CNT_W'(BUFFER_SIZE - OFF_MARGIN);

  typedef enum logic [1:0] {IDLE, VA, SA} state_t;

  flit_t                          head_flit [VC_NUM];
  logic [VC_NUM-1:0][VC_SIZE-1:0] ds_vc;

  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    flit_t              mem [BUFFER_SIZE];
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [CNT_W-1:0]   count;
    state_t             state, state_nx;
    logic               end_packet, end_packet_nx;
    logic               wr_sel, type_ok, wr_ok, rd_ok, rd_last, full, empty;
    port_t              out_port_q;
    logic [VC_SIZE-1:0] ds_q;
    logic               alloc_q, err_q;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign wr_sel  = valid_i && (data_i.vc_id == VC_SIZE'(v));
    assign wr_ok   = wr_sel && !full && type_ok;
    assign rd_ok   = read_i[v] && (state == SA) && !empty;
    assign rd_last = rd_ok && ((mem[rd_ptr].flit_label == TAIL) ||
                               (mem[rd_ptr].flit_label == HEADTAIL));

    always_comb begin
      type_ok = 1'b0;
      if (state == IDLE)
        type_ok = (data_i.flit_label == HEAD) || (data_i.flit_label == HEADTAIL);
      else
        type_ok = ((data_i.flit_label == BODY) || (data_i.flit_label == TAIL)) && !end_packet;
    end

    always_comb begin
      state_nx      = state;
      end_packet_nx = end_packet;
      unique case (state)
        IDLE: if (wr_ok) begin
          state_nx      = VA;
          end_packet_nx = (data_i.flit_label == HEADTAIL);
        end
        VA: begin
          if (vc_valid_i[v]) state_nx = SA;
          if (wr_ok && data_i.flit_label == TAIL) end_packet_nx = 1'b1;
        end
        SA: begin
          if (wr_ok && data_i.flit_label == TAIL) end_packet_nx = 1'b1;
          if (rd_last) begin
            state_nx      = IDLE;
            end_packet_nx = 1'b0;
          end
        end
        default: state_nx = IDLE;
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state      <= IDLE;
        end_packet <= 1'b0;
      end else begin
        state      <= state_nx;
        end_packet <= end_packet_nx;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        count      <= '0;
        out_port_q <= LOCAL;
        ds_q       <= '0;
        alloc_q    <= 1'b0;
        err_q      <= 1'b0;
      end else begin
        if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
        if (rd_ok) rd_ptr <= rd_ptr + PTR_W'(1);
        case ({wr_ok, rd_ok})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
        if (state == IDLE && wr_ok) out_port_q <= out_port_i;
        if (state == VA && vc_valid_i[v]) ds_q <= vc_new_i[v];
        alloc_q <= rd_last;
        // Illegal writes and reads both latch the error until reset.
        err_q   <= err_q | (wr_sel && !wr_ok) | (read_i[v] && !rd_ok);
      end
    end

    // Storage is not reset: pointers and count define validity.
    always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= data_i;
    end

    assign head_flit[v]        = mem[rd_ptr];
    assign ds_vc[v]            = ds_q;
    assign is_full_o[v]        = full;
    assign is_empty_o[v]       = empty;
    assign on_off_o[v]         = (count < ON_LIMIT);
    assign out_port_o[v]       = out_port_q;
    assign vc_request_o[v]     = (state == VA);
    assign switch_request_o[v] = (state == SA) && !empty;
    assign vc_allocatable_o[v] = alloc_q;
    assign downstream_vc_o[v]  = ds_q;
    assign error_o[v]          = err_q;
  end

  always_comb begin
    data_o = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      if (read_i[v]) begin
        data_o       = head_flit[v];
        data_o.vc_id = ds_vc[v];
      end
    end
  end

  a_read_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(read_i));

endmodule

// File: tb/tb_vc_input_unit.sv
// Directed bench for vc_input_unit: expected flits are queued per VC on write
// and compared against data_o when the VC is read.
module tb_vc_input_unit;
  import noc_params::*;

  logic                   clk, rst;
  flit_t                  data_i;
  logic                   valid_i;
  port_t                  out_port_i;
  logic [1:0]             vc_valid_i;
  logic [1:0][0:0]        vc_new_i;
  logic [1:0]             read_i;
  flit_t                  data_o;
  logic [1:0]             is_full_o, is_empty_o, on_off_o;
  port_t [1:0]            out_port_o;
  logic [1:0]             vc_request_o, switch_request_o, vc_allocatable_o, error_o;
  logic [1:0][0:0]        downstream_vc_o;

  int n_assert = 0;
  int n_fail   = 0;
  flit_t exp_q [2][$];

  vc_input_unit #(.VC_NUM(2), .BUFFER_SIZE(8), .OFF_MARGIN(5)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i),
    .out_port_i(out_port_i), .vc_valid_i(vc_valid_i), .vc_new_i(vc_new_i),
    .read_i(read_i), .data_o(data_o), .is_full_o(is_full_o),
    .is_empty_o(is_empty_o), .on_off_o(on_off_o), .out_port_o(out_port_o),
    .vc_request_o(vc_request_o), .switch_request_o(switch_request_o),
    .vc_allocatable_o(vc_allocatable_o), .downstream_vc_o(downstream_vc_o),
    .error_o(error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    valid_i    = 1'b0;
    vc_valid_i = '0;
    read_i     = '0;
  endtask

  task automatic wr(input int v, input flit_label_t lab, input logic [15:0] pl,
                    input port_t p, input bit acc);
    data_i.flit_label = lab;
    data_i.vc_id      = 1'(v);
    data_i.data       = pl;
    out_port_i        = p;
    valid_i           = 1'b1;
    if (acc) exp_q[v].push_back(data_i);
  endtask

  // Drives a read, then at mid-cycle compares data_o with the queued flit.
  task automatic rd_chk(input int v, input logic ds, input string tag);
    flit_t e;
    read_i    = '0;
    read_i[v] = 1'b1;
    #4;
    n_assert++;
    assert (exp_q[v].size() != 0) else begin
      n_fail++;
      $error("FAIL %s observed=empty_queue expected=flit", tag);
    end
    if (exp_q[v].size() != 0) begin
      e = exp_q[v].pop_front();
      e.vc_id = ds;
      chk(tag, 64'(data_o), 64'(e));
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_empty"},   64'(is_empty_o), 64'(2'b11));
    chk({tag, "_full"},    64'(is_full_o), 64'(2'b00));
    chk({tag, "_onoff"},   64'(on_off_o), 64'(2'b11));
    chk({tag, "_err"},     64'(error_o), 64'(2'b00));
    chk({tag, "_alloc"},   64'(vc_allocatable_o), 64'(2'b00));
    chk({tag, "_vcreq"},   64'(vc_request_o), 64'(2'b00));
    chk({tag, "_swreq"},   64'(switch_request_o), 64'(2'b00));
    chk({tag, "_port0"},   64'(out_port_o[0]), 64'(LOCAL));
    chk({tag, "_port1"},   64'(out_port_o[1]), 64'(LOCAL));
    chk({tag, "_dsvc"},    64'(downstream_vc_o), 64'(0));
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; data_i = '0; out_port_i = LOCAL;
    vc_valid_i = '0; vc_new_i = '0; read_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst = 1'b0;

    // 4-flit packet on VC1 to EAST, downstream VC 0
    wr(1, HEAD, 16'h1001, EAST, 1); cyc();
    chk("t1_vcreq", 64'(vc_request_o), 64'(2'b10));
    chk("t1_port", 64'(out_port_o[1]), 64'(EAST));
    wr(1, BODY, 16'h1002, LOCAL, 1); vc_valid_i = 2'b10; vc_new_i[1] = 1'b0; cyc();
    chk("t1_swreq", 64'(switch_request_o), 64'(2'b10));
    wr(1, BODY, 16'h1003, LOCAL, 1); rd_chk(1, 1'b0, "t1_rd0"); cyc();
    wr(1, TAIL, 16'h1004, LOCAL, 1); rd_chk(1, 1'b0, "t1_rd1"); cyc();
    rd_chk(1, 1'b0, "t1_rd2"); cyc();
    chk("t1_alloc_early", 64'(vc_allocatable_o), 64'(2'b00));
    rd_chk(1, 1'b0, "t1_rd3"); cyc();
    chk("t1_alloc_pulse", 64'(vc_allocatable_o), 64'(2'b10));
    chk("t1_idle", 64'(vc_request_o | switch_request_o), 64'(2'b00));
    cyc();
    chk("t1_alloc_end", 64'(vc_allocatable_o), 64'(2'b00));
    chk("t1_empty", 64'(is_empty_o), 64'(2'b11));

    // HEADTAIL on VC0, downstream VC 1, then a new packet right after the pulse
    wr(0, HEADTAIL, 16'h2001, NORTH, 1); cyc();
    vc_valid_i = 2'b01; vc_new_i[0] = 1'b1; cyc();
    chk("t2_dsvc", 64'(downstream_vc_o[0]), 64'(1));
    rd_chk(0, 1'b1, "t2_rd_ht"); cyc();
    chk("t2_alloc_pulse", 64'(vc_allocatable_o), 64'(2'b01));
    cyc();
    wr(0, HEAD, 16'h2002, WEST, 1); cyc();
    chk("t2_new_head", 64'(vc_request_o[0]), 64'(1'b1));
    chk("t2_no_err", 64'(error_o), 64'(2'b00));
    wr(0, TAIL, 16'h2003, LOCAL, 1); vc_valid_i = 2'b01; vc_new_i[0] = 1'b0; cyc();
    rd_chk(0, 1'b0, "t2_rd_h"); cyc();
    rd_chk(0, 1'b0, "t2_rd_t"); cyc();
    chk("t2_alloc2", 64'(vc_allocatable_o), 64'(2'b01));

    // Interleaved packets on VC0 (WEST, ds 1) and VC1 (SOUTH, ds 0)
    wr(0, HEAD, 16'h3001, WEST, 1); cyc();
    wr(1, HEAD, 16'h3101, SOUTH, 1); vc_valid_i = 2'b01; vc_new_i[0] = 1'b1; cyc();
    wr(0, BODY, 16'h3002, LOCAL, 1); vc_valid_i = 2'b10; vc_new_i[1] = 1'b0;
    rd_chk(0, 1'b1, "t5_h0"); cyc();
    wr(1, BODY, 16'h3102, LOCAL, 1); rd_chk(1, 1'b0, "t5_h1"); cyc();
    wr(0, TAIL, 16'h3003, LOCAL, 1); rd_chk(0, 1'b1, "t5_b0"); cyc();
    rd_chk(1, 1'b0, "t5_b1"); cyc();
    chk("t5_swreq_vc1_empty", 64'(switch_request_o), 64'(2'b01));
    wr(1, TAIL, 16'h3103, LOCAL, 1); rd_chk(0, 1'b1, "t5_t0"); cyc();
    chk("t5_swreq_b", 64'(switch_request_o), 64'(2'b10));
    chk("t5_alloc0", 64'(vc_allocatable_o), 64'(2'b01));
    rd_chk(1, 1'b0, "t5_t1"); cyc();
    chk("t5_alloc1", 64'(vc_allocatable_o), 64'(2'b10));
    chk("t5_swreq_c", 64'(switch_request_o), 64'(2'b00));
    chk("t5_port0", 64'(out_port_o[0]), 64'(WEST));
    chk("t5_port1", 64'(out_port_o[1]), 64'(SOUTH));

    // Protocol errors: BODY into IDLE VC0, read of VC1 while in VA
    wr(0, BODY, 16'h4001, LOCAL, 0); cyc();
    chk("t6_err_body", 64'(error_o), 64'(2'b01));
    chk("t6_vc0_idle", 64'(vc_request_o[0]), 64'(1'b0));
    chk("t6_vc0_empty", 64'(is_empty_o[0]), 64'(1'b1));
    wr(1, HEAD, 16'h4101, NORTH, 1); cyc();
    read_i = 2'b10; cyc();
    chk("t6_err_rd", 64'(error_o), 64'(2'b11));
    chk("t6_vc1_va", 64'(vc_request_o[1]), 64'(1'b1));
    chk("t6_vc1_kept", 64'(is_empty_o[1]), 64'(1'b0));
    wr(1, BODY, 16'h4102, LOCAL, 1); cyc();
    rst = 1'b1; #1;
    chk_reset_vals("midrst");
    exp_q[0].delete(); exp_q[1].delete();
    @(posedge clk); #1; rst = 1'b0;

    // Fill VC0 without reads: on/off threshold and overflow
    wr(0, HEAD, 16'h5000, NORTH, 1); cyc();
    chk("t3_onoff_1", 64'(on_off_o[0]), 64'(1'b1));
    for (int k = 2; k <= 8; k++) begin
      wr(0, BODY, 16'(16'h5000 + k), LOCAL, 1); cyc();
      chk("t3_onoff", 64'(on_off_o[0]), 64'(k < 3));
      chk("t3_full", 64'(is_full_o[0]), 64'(k == 8));
    end
    chk("t3_err_before", 64'(error_o[0]), 64'(1'b0));
    wr(0, BODY, 16'h5009, LOCAL, 0); cyc();
    chk("t3_err_ovf", 64'(error_o[0]), 64'(1'b1));
    chk("t3_full_kept", 64'(is_full_o[0]), 64'(1'b1));

    // Full VC1 in SA: simultaneous write (refused) and read
    wr(1, HEAD, 16'h6000, EAST, 1); cyc();
    chk("t4_port", 64'(out_port_o[1]), 64'(EAST));
    for (int k = 2; k <= 8; k++) begin
      wr(1, BODY, 16'(16'h6000 + k), LOCAL, 1); cyc();
    end
    chk("t4_full", 64'(is_full_o[1]), 64'(1'b1));
    vc_valid_i = 2'b10; vc_new_i[1] = 1'b1; cyc();
    chk("t4_swreq", 64'(switch_request_o[1]), 64'(1'b1));
    wr(1, BODY, 16'hdead, LOCAL, 0); rd_chk(1, 1'b1, "t4_rd_full"); cyc();
    chk("t4_not_full", 64'(is_full_o[1]), 64'(1'b0));
    chk("t4_err", 64'(error_o[1]), 64'(1'b1));
    chk("t4_onoff", 64'(on_off_o[1]), 64'(1'b0));
    for (int k = 0; k < 7; k++) begin
      rd_chk(1, 1'b1, "t4_drain"); cyc();
    end
    chk("t4_empty", 64'(is_empty_o[1]), 64'(1'b1));
    chk("t4_swreq_empty", 64'(switch_request_o[1]), 64'(1'b0));
    chk("t4_onoff_back", 64'(on_off_o[1]), 64'(1'b1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/vc_input_unit.md
Name: vc_input_unit

Overview:
Multi-VC input unit for one router input port: VC_NUM independent per-VC FIFOs, each with its own IDLE/VA/SA packet state machine. It demultiplexes incoming flits by flit vc_id and latches the route and the downstream VC per packet. It raises per-VC VA and SA requests and muxes the switch-granted VC onto a single output flit. Adds over the single-VC buffer: HEADTAIL packets, SA requests gated on non-empty, configurable on/off margin, sticky protocol-error flags.

Parameters:
VC_NUM, 2, number of virtual channels (= 2**VC_SIZE from noc_params)
BUFFER_SIZE, 8, flit slots per VC; power of two, >= 2
OFF_MARGIN, 5, free-slot margin covering the upstream loop latency; 0 < OFF_MARGIN < BUFFER_SIZE

Ports:
clk  in  1  clock
rst  in  1  reset
data_i  in  flit_t  incoming flit; data_i.vc_id selects the target VC
valid_i  in  1  data_i valid this cycle
out_port_i  in  port_t  route-computation result for the head flit on data_i
vc_valid_i  in  VC_NUM  per-VC VA grant
vc_new_i  in  VC_NUM x VC_SIZE  per-VC allocated downstream VC
read_i  in  VC_NUM  SA grant; one-hot or zero
data_o  out  flit_t  head flit of the granted VC; vc_id replaced by that VC's downstream_vc_o
is_full_o  out  VC_NUM  per-VC occupancy == BUFFER_SIZE
is_empty_o  out  VC_NUM  per-VC occupancy == 0
on_off_o  out  VC_NUM  1 iff occupancy < BUFFER_SIZE - OFF_MARGIN
out_port_o  out  VC_NUM x port_t  latched route per VC
vc_request_o  out  VC_NUM  VC is in state VA
switch_request_o  out  VC_NUM  VC is in SA and non-empty
vc_allocatable_o  out  VC_NUM  1-cycle pulse after the packet's last flit leaves
downstream_vc_o  out  VC_NUM x VC_SIZE  latched downstream VC
error_o  out  VC_NUM  sticky protocol-violation flag

Behaviour:
- Reset is asynchronous and active-high; clock is clk. On reset: all VCs IDLE, FIFOs empty, pointers 0, end_packet 0. Outputs reset to: out_port_o LOCAL, downstream_vc_o 0, vc_allocatable_o 0, error_o 0, is_empty_o all 1, is_full_o 0, on_off_o all 1. Reset mid-packet discards all buffered flits.
- Write: a flit is accepted into VC v = data_i.vc_id when valid_i = 1 and the acceptance rules below allow it. Accepted flits are stored on the clock edge and are visible on data_o from the next cycle if read_i[v] = 1. Minimum write-to-read latency is 1 cycle.
- Read: read_i[v] = 1 pops the head flit of VC v on the clock edge. data_o is combinational from FIFO head and read_i; with read_i = 0, data_o is don't-care.
- Same-VC write and read in one cycle both take effect; occupancy is unchanged. is_full_o is evaluated before the read, so a write to a full VC is refused even when a read of that VC occurs in the same cycle.
- Occupancy counter width is log2(BUFFER_SIZE)+1. Pointers wrap modulo BUFFER_SIZE.
- Per-VC FSM:
  - IDLE: accept HEAD or HEADTAIL only. Latch out_port_i and go to VA. HEADTAIL also sets end_packet.
  - VA: vc_request_o = 1. On vc_valid_i[v], latch vc_new_i[v] and go to SA next cycle. Accept BODY/TAIL while end_packet = 0; TAIL sets end_packet.
  - SA: switch_request_o = is_empty_o ? 0 : 1. Accept BODY/TAIL while end_packet = 0; TAIL sets end_packet. On a read whose flit label is TAIL or HEADTAIL: go to IDLE, clear end_packet, pulse vc_allocatable_o for 1 cycle (next cycle).
- Protocol errors: the flit is dropped (no write) and error_o[v] is set; it stays set until reset. Error cases:
  - write to a full VC;
  - HEAD/HEADTAIL received while not IDLE;
  - BODY/TAIL received in IDLE;
  - any flit received after end_packet is set;
  - read_i[v] while VC v is not in SA or is empty (the read is ignored).
- read_i with more than one bit set is illegal and is covered by an assertion; no RTL recovery.
- VCs are fully independent. A VA grant and an SA read on different VCs in the same cycle are both honoured.

Test Plan:
- Reset, then a 4-flit packet (H,B,B,T) to VC1 with out_port_i = EAST; vc_valid_i[1] with vc_new_i[1] = 0; read_i[1] held -> out_port_o[1] = EAST, four flits out in order, each with vc_id 0; vc_allocatable_o[1] pulses exactly once; VC1 returns to IDLE.
- HEADTAIL to VC0, then VA grant -> one read; vc_allocatable_o[0] pulses; a new HEAD on VC0 is accepted the cycle after the pulse.
- BUFFER_SIZE = 8, OFF_MARGIN = 5, no reads -> on_off_o falls when occupancy reaches 3. The 9th flit is dropped, error_o = 1, is_full_o = 1.
- Full VC in SA with simultaneous write and read_i -> read occurs, write refused, error_o set, occupancy goes to 7.
- Interleaved packets on VC0/VC1 with alternating read_i -> per-VC order preserved; switch_request_o drops to 0 whenever a VC is empty.
- BODY to IDLE VC, and read_i on a VC in VA -> both dropped/ignored, error_o set, no state change; assert rst mid-packet -> all outputs return to reset values.
